// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder
// Desc    : Digit-serial adder/subtractor that handles DIGIT bits per clock,
//           least-significant digit first. Optional ovf port: SERIAL_ADDER_OVF_EN
// Rev     : 1.0
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_N  = WIDTH / DIGIT;
  localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [WIDTH-1:0]       res_q;
  logic                   carry_q;
  logic [c_CW-1:0]        cnt_q;

  logic [DIGIT:0]         w_dsum;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_res_d;

  // Operands shift right each digit, so the active digit is always the low slice.
  assign w_dsum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign w_cat   = {w_dsum[DIGIT-1:0], res_q};
  assign w_res_d = w_cat[WIDTH+DIGIT-1:DIGIT];

`ifdef SERIAL_ADDER_OVF_EN
  logic w_msb_cin;
  // Carry into the result MSB, recovered from the MSB sum bit of the last digit.
  assign w_msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ w_dsum[DIGIT-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= w_res_d;
          carry_q <= w_dsum[DIGIT];
          cnt_q   <= cnt_q + c_CW'(1);
          if (cnt_q == c_LAST) begin
            sum     <= w_res_d;
            cout    <= w_dsum[DIGIT];
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= w_msb_cin ^ w_dsum[DIGIT];
`endif
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Testbench for serial_adder: directed table on WIDTH=8/DIGIT=1, back-to-back,
// mid-operation reset, and a random sweep over 16/4, 16/16 and 8/2 instances.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance, WIDTH=8, DIGIT=1
  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  // Sweep instances share one set of inputs
  logic        sstart, ssub, scin;
  logic [15:0] sa, sb;
  logic        busy1, done1, cout1;
  logic [15:0] sum1;
  logic        busy2, done2, cout2;
  logic [15:0] sum2;
  logic        busy3, done3, cout3;
  logic [7:0]  sum3;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf, ovf1, ovf2, ovf3;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_d16_4 (
    .clk(clk), .rst_n(rst_n), .start(sstart), .sub(ssub), .a(sa), .b(sb), .cin(scin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16_16 (
    .clk(clk), .rst_n(rst_n), .start(sstart), .sub(ssub), .a(sa), .b(sb), .cin(scin),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d8_2 (
    .clk(clk), .rst_n(rst_n), .start(sstart), .sub(ssub), .a(sa[7:0]), .b(sb[7:0]), .cin(scin),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf3)
`endif
  );

  typedef struct {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // {cout, sum[15:0]} from plain integer arithmetic
  function automatic logic [16:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    longint r, m;
    logic [16:0] res;
    m   = (longint'(1) << w) - 1;
    res = '0;
    if (!sb) begin
      r       = longint'(x) + longint'(y) + longint'(ci);
      res[16] = ((r >> w) & 1) != 0;
    end else begin
      r       = longint'(x) - longint'(y) - longint'(ci);
      res[16] = (r >= 0);
    end
    res[15:0] = 16'(r & m);
    return res;
  endfunction

  function automatic logic model_ovf(input int w, input logic [15:0] x, input logic [15:0] y,
                                     input logic ci, input logic sb);
    longint sx, sy, r, hi, lo;
    sx = longint'(x);
    sy = longint'(y);
    if (x[w-1]) sx = sx - (longint'(1) << w);
    if (y[w-1]) sy = sy - (longint'(1) << w);
    r  = sb ? (sx - sy - longint'(ci)) : (sx + sy + longint'(ci));
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    return (r > hi) || (r < lo);
  endfunction

  // One operation on the main instance; inputs are scrambled and start is
  // toggled while it runs, none of which may disturb the result.
  task automatic run_op(input vec_t v, input int idx);
    int lat, busy_n;
    logic held;
    logic [7:0] prev;
    prev = sum;
    held = 1'b1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    tick();
    lat = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if (sum !== prev) held = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      start = 1'($urandom);
      tick();
      lat++;
    end
    start = 1'b0;
    chk($sformatf("v%0d latency", idx), lat, 8);
    chk($sformatf("v%0d busy cycles", idx), busy_n, 8);
    chk($sformatf("v%0d sum held while running", idx), held, 1);
    chk($sformatf("v%0d busy low at done", idx), busy, 0);
    chk($sformatf("v%0d sum", idx), sum, v.exp_sum);
    chk($sformatf("v%0d cout", idx), cout, v.exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
    chk($sformatf("v%0d ovf", idx), ovf, v.exp_ovf);
`endif
    tick();
    chk($sformatf("v%0d done one cycle", idx), done, 0);
    chk($sformatf("v%0d sum kept", idx), {cout, sum}, {v.exp_cout, v.exp_sum});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  qa[40], qb[40];
    logic        qc[40], qs[40];
    logic [16:0] e, e8;
    logic        stable, seen;
    int          ndone, lat1, lat2, lat3;
    logic [16:0] g1, g2;
    logic [8:0]  g3;
`ifdef SERIAL_ADDER_OVF_EN
    logic        o1, o2, o3;
`endif

    //           sub   cin   a      b      sum    cout  ovf
    vecs[0] = '{1'b0, 1'b1, 8'h5A, 8'h33, 8'h8E, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'h05, 8'h07, 8'hFD, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h20, 8'h10, 8'h0F, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 8'hC8, 8'h64, 8'h2D, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    sstart = 1'b0; ssub = 1'b0; scin = 1'b0; sa = '0; sb = '0;

    // Reset state and idle stability
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset ovf", ovf, 0);
`endif
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({busy, done, cout, sum} !== 11'd0) stable = 1'b0;
    end
    chk("idle outputs stable", stable, 1);

    // Directed table
    for (int i = 0; i < 10; i++) run_op(vecs[i], i);

    // Reset on the 4th RUN edge aborts without a done pulse
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort no done pulse", ndone, 0);
    run_op(vecs[0], 100);

    // Back-to-back: start held high, fresh operands every cycle
    start = 1'b1;
    for (int t = 0; t < 30; t++) begin
      qa[t] = 8'($urandom); qb[t] = 8'($urandom); qc[t] = 1'($urandom); qs[t] = 1'($urandom);
      a = qa[t]; b = qb[t]; cin = qc[t]; sub = qs[t];
      tick();
      chk($sformatf("b2b done t%0d", t), done, ((t % 9) == 8) ? 1 : 0);
      if (((t % 9) == 8) && done) begin
        e = model(8, {8'h00, qa[t-8]}, {8'h00, qb[t-8]}, qc[t-8], qs[t-8]);
        chk($sformatf("b2b result t%0d", t), {cout, sum}, {e[16], e[7:0]});
      end
    end
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      seen = done;
    end
    chk("b2b drain done", seen, 1);
    e = model(8, {8'h00, qa[27]}, {8'h00, qb[27]}, qc[27], qs[27]);
    chk("b2b drain result", {cout, sum}, {e[16], e[7:0]});
    tick();

    // Width/digit sweep
    for (int i = 0; i < 200; i++) begin
      sa = 16'($urandom); sb = 16'($urandom); scin = 1'($urandom); ssub = 1'($urandom);
      sstart = 1'b1;
      tick();
      sstart = 1'b0;
      lat1 = -1; lat2 = -1; lat3 = -1;
      g1 = '0; g2 = '0; g3 = '0;
`ifdef SERIAL_ADDER_OVF_EN
      o1 = 1'b0; o2 = 1'b0; o3 = 1'b0;
`endif
      for (int c = 1; c <= 6; c++) begin
        tick();
        if (done1 && lat1 < 0) begin
          lat1 = c; g1 = {cout1, sum1};
`ifdef SERIAL_ADDER_OVF_EN
          o1 = ovf1;
`endif
        end
        if (done2 && lat2 < 0) begin
          lat2 = c; g2 = {cout2, sum2};
`ifdef SERIAL_ADDER_OVF_EN
          o2 = ovf2;
`endif
        end
        if (done3 && lat3 < 0) begin
          lat3 = c; g3 = {cout3, sum3};
`ifdef SERIAL_ADDER_OVF_EN
          o3 = ovf3;
`endif
        end
      end
      e  = model(16, sa, sb, scin, ssub);
      e8 = model(8, {8'h00, sa[7:0]}, {8'h00, sb[7:0]}, scin, ssub);
      chk($sformatf("sweep%0d 16/4 latency", i), lat1, 4);
      chk($sformatf("sweep%0d 16/16 latency", i), lat2, 1);
      chk($sformatf("sweep%0d 8/2 latency", i), lat3, 4);
      chk($sformatf("sweep%0d 16/4 result", i), g1, e);
      chk($sformatf("sweep%0d 16/16 result", i), g2, e);
      chk($sformatf("sweep%0d 8/2 result", i), g3, {e8[16], e8[7:0]});
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("sweep%0d ovf", i), {o1, o2, o3},
          {model_ovf(16, sa, sb, scin, ssub), model_ovf(16, sa, sb, scin, ssub),
           model_ovf(8, {8'h00, sa[7:0]}, {8'h00, sb[7:0]}, scin, ssub)});
`endif
      chk($sformatf("sweep%0d idle", i), {busy1, busy2, busy3}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor that processes operands DIGIT bits per clock, least-significant digit first.
- It is the sequential successor to the single-bit full adder. A carry flip-flop links the digits across cycles.
- It uses a start/busy/done handshake and holds its result until the next operation.
- Intended for area-constrained datapaths where WIDTH-bit ripple adders are too large.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 2.
- DIGIT, 1, bits added per clock. Must divide WIDTH exactly (elaboration-time check).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0: a + b + cin; 1: a - b - cin.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in (add) or borrow-in (sub); captured on the accepting edge.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held between operations.
- cout  output  1  add: carry-out; sub: 1 = no borrow.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Digit counter and carry flip-flop cleared.
  - Reset mid-operation aborts the operation immediately; no done pulse is produced.
- N = WIDTH/DIGIT. States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 at an edge (edge E0):
  - Capture a.
  - Capture b, or ~b when sub=1.
  - Load the carry flip-flop with cin, or ~cin when sub=1.
  - cnt=0; go to RUN. busy=1 from the next cycle.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE; done drops.
- RUN, each edge Ek (k=1..N):
  - Add digit cnt of A, digit cnt of B and the carry flip-flop.
  - Write the DIGIT-bit result into the internal shift register.
  - Carry flip-flop takes the digit carry-out; cnt increments.
  - Arithmetic per digit is (DIGIT+1)-bit unsigned.
- Edge EN (cnt = N-1):
  - sum ← completed internal result; cout ← final carry.
  - State → DONE; busy=0; done=1 for exactly the cycle after EN.
- Latency: done is high N cycles after the edge that accepted start. WIDTH=8, DIGIT=1 gives 8; WIDTH=8, DIGIT=4 gives 2.
- Throughput: start asserted during the DONE cycle is accepted. Back-to-back operations therefore cost N+1 cycles each.
- start while busy=1 is ignored, with no queuing. Changes to a, b, cin and sub during RUN have no effect.
- sum and cout change only at EN and at reset. Intermediate digits are never visible on sum.
- Wrap-around: the result is modulo 2^WIDTH; the overflowed bit appears on cout only.
- DIGIT=WIDTH is legal: single-cycle RUN, latency 1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow of the completed operation.
  - ovf = carry into the MSB XOR carry out of the MSB, evaluated on the final digit.
  - Updated at EN together with sum; reset to 0; held otherwise.
- When undefined:
  - No ovf port and no related logic; port list exactly as above.

Test Plan:
- Reset check: rst_n=0 for 2 cycles, then release → busy=0, done=0, sum=0, cout=0. Hold start=0 for 5 cycles → all outputs unchanged.
- Basic add, WIDTH=8, DIGIT=1: a=8'h5A, b=8'h33, cin=1, sub=0, one start pulse → busy high for 8 cycles. done pulses 8 cycles after accept with sum=8'h8E, cout=0.
- Carry wrap and subtract: a=8'hFF, b=8'h01, cin=0, sub=0 → sum=8'h00, cout=1. Then a=8'h10, b=8'h20, cin=0, sub=1 → sum=8'hF0, cout=0. With SERIAL_ADDER_OVF_EN: a=8'h7F + b=8'h01 → ovf=1.
- Back-to-back and ignored start:
  - start held continuously with new operands each cycle → exactly one done per 9 cycles.
  - Each result matches the operands captured at its own accept edge.
  - Operands changed during RUN do not alter the result.
- Reset mid-operation: start, then rst_n=0 at the 4th RUN cycle → no done pulse; sum=0, state IDLE. A new start afterwards completes normally.
- Width/digit sweep at WIDTH=16, DIGIT=4, DIGIT=16, and WIDTH=8, DIGIT=2: 200 random operands with random sub and cin → sum/cout match the reference model. Latency is 4, 1 and 4 cycles respectively.
